// File: rtl/tas_avg_p.sv
// tas_avg_p: deserialises an LSB-first serial stream into header+sample packets and writes the truncated average of kept packets to RAM
module tas_avg_p #(
  parameter int DATA_W = 8,
  parameter int NSAMP_LOG2 = 2,
  parameter int ADDR_W = 11,
  parameter logic [DATA_W-1:0] HDR_KEEP = 8'hC3,
  parameter logic [ADDR_W-1:0] START_ADDR = '1,
  parameter bit DIR_DOWN = 1'b1
) (
  input  logic              clk_50,
  input  logic              reset,
  input  logic              serial_data,
  input  logic              data_ena,
  output logic              ram_wr_n,
  output logic [DATA_W-1:0] ram_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              pkt_drop
);
  localparam int BC_W = $clog2(DATA_W);
  localparam int ACC_W = DATA_W + NSAMP_LOG2;
  typedef enum logic [1:0] {HDR, SAMP, SKIP} pkt_t;
  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} wr_t;
  logic [BC_W-1:0] bit_cnt;
  logic [DATA_W-1:0] sr;
  logic word_valid;
  logic bit_last;
  pkt_t pkt_q, pkt_d;
  wr_t wr_q, wr_d;
  logic [NSAMP_LOG2-1:0] cnt;
  logic [ACC_W-1:0] acc;
  logic wr_req;
  logic last;
  logic hdr_ok;
  assign bit_last = bit_cnt == BC_W'(DATA_W - 1);
  assign last = cnt == '1;
  assign hdr_ok = sr == HDR_KEEP;
  assign ram_wr_n = wr_q != STROBE;
  always_ff @(posedge clk_50) begin
    if (reset) begin
      bit_cnt <= '0;
      sr <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= data_ena && bit_last;
      if (data_ena) begin
        sr <= {serial_data, sr[DATA_W-1:1]};
        bit_cnt <= bit_last ? '0 : bit_cnt + 1'b1;
      end else begin
        bit_cnt <= '0;
      end
    end
  end
  always_comb begin
    pkt_d = pkt_q;
    if (word_valid)
      pkt_d = pkt_q == HDR ? (hdr_ok ? SAMP : SKIP) : (last ? HDR : pkt_q);
  end
  always_ff @(posedge clk_50) begin
    if (reset) begin
      pkt_q <= HDR;
      cnt <= '0;
      acc <= '0;
      wr_req <= 1'b0;
      pkt_drop <= 1'b0;
    end else begin
      pkt_q <= pkt_d;
      wr_req <= word_valid && pkt_q == SAMP && last;
      pkt_drop <= word_valid && pkt_q == HDR && !hdr_ok;
      if (word_valid) begin
        cnt <= pkt_q == HDR ? '0 : cnt + 1'b1;
        acc <= pkt_q == HDR ? '0 : pkt_q == SAMP ? acc + ACC_W'(sr) : acc;
      end
    end
  end
  // three-phase strobe: data/address settle in SETUP, held through HOLD
  always_comb begin
    wr_d = wr_q == IDLE ? (wr_req ? SETUP : IDLE) : wr_q == SETUP ? STROBE : wr_q == STROBE ? HOLD : IDLE;
  end
  always_ff @(posedge clk_50) begin
    if (reset) begin
      wr_q <= IDLE;
      ram_data <= '0;
      ram_addr <= START_ADDR;
    end else begin
      wr_q <= wr_d;
      if (wr_q == IDLE && wr_req) ram_data <= acc[ACC_W-1:NSAMP_LOG2];
      if (wr_q == HOLD) ram_addr <= DIR_DOWN ? ram_addr - 1'b1 : ram_addr + 1'b1;
    end
  end
endmodule

// File: tb/tb_tas_avg_p.sv
// tb_tas_avg_p: randomized packets against a packet-level averaging model, four parametrisations
module tb_tas_avg_p;
  logic clk_50 = 1'b0;
  logic reset = 1'b1;
  logic sd = 1'b0, en = 1'b0, sd3 = 1'b0, en3 = 1'b0;
  always #10 clk_50 = ~clk_50;
  logic [2:0] wr_n, drop;
  logic [7:0] rd [3];
  logic [10:0] ra [3];
  logic wr_n3, drop3;
  logic [11:0] rd3;
  logic [10:0] ra3;
  tas_avg_p u0 (.clk_50(clk_50), .reset(reset), .serial_data(sd), .data_ena(en),
    .ram_wr_n(wr_n[0]), .ram_data(rd[0]), .ram_addr(ra[0]), .pkt_drop(drop[0]));
  tas_avg_p #(.START_ADDR(11'h000), .DIR_DOWN(1'b1)) u1 (.clk_50(clk_50), .reset(reset), .serial_data(sd), .data_ena(en),
    .ram_wr_n(wr_n[1]), .ram_data(rd[1]), .ram_addr(ra[1]), .pkt_drop(drop[1]));
  tas_avg_p #(.START_ADDR(11'h7FF), .DIR_DOWN(1'b0)) u2 (.clk_50(clk_50), .reset(reset), .serial_data(sd), .data_ena(en),
    .ram_wr_n(wr_n[2]), .ram_data(rd[2]), .ram_addr(ra[2]), .pkt_drop(drop[2]));
  tas_avg_p #(.DATA_W(12), .NSAMP_LOG2(3), .HDR_KEEP(12'hC3C)) u3 (.clk_50(clk_50), .reset(reset), .serial_data(sd3), .data_ena(en3),
    .ram_wr_n(wr_n3), .ram_data(rd3), .ram_addr(ra3), .pkt_drop(drop3));
  localparam logic [10:0] START [4] = '{11'h7FF, 11'h000, 11'h7FF, 11'h7FF};
  localparam bit DN [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
  logic [3:0] mwn, mdrop;
  logic [11:0] md [4];
  logic [10:0] ma [4];
  assign mwn = {wr_n3, wr_n};
  assign mdrop = {drop3, drop};
  assign md[0] = 12'(rd[0]);
  assign md[1] = 12'(rd[1]);
  assign md[2] = 12'(rd[2]);
  assign md[3] = rd3;
  assign ma[0] = ra[0];
  assign ma[1] = ra[1];
  assign ma[2] = ra[2];
  assign ma[3] = ra3;
  int checks = 0, errors = 0;
  logic [22:0] eq [4][$];
  logic [10:0] maddr [4];
  int lw [4] = '{0, 0, 0, 0};
  int dseen [4] = '{0, 0, 0, 0};
  int drop_exp8 = 0, drop_exp12 = 0;
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  always @(negedge clk_50) begin
    for (int i = 0; i < 4; i++) begin
      if (!mwn[i]) begin
        lw[i]++;
        if (eq[i].size() == 0) check($sformatf("unexp_wr%0d", i), int'(mwn[i]), 1);
        else begin
          logic [22:0] e;
          e = eq[i].pop_front();
          check($sformatf("wr_data%0d", i), int'(md[i]), int'(e[11:0]));
          check($sformatf("wr_addr%0d", i), int'(ma[i]), int'(e[22:12]));
        end
      end else begin
        if (lw[i] > 0) check($sformatf("strobe_w%0d", i), lw[i], 1);
        lw[i] = 0;
      end
      if (mdrop[i]) dseen[i]++;
    end
  end
  task automatic chk_rst();
    for (int i = 0; i < 4; i++) begin
      check("rst_wr_n", int'(mwn[i]), 1);
      check("rst_data", int'(md[i]), 0);
      check("rst_addr", int'(ma[i]), int'(START[i]));
      check("rst_drop", int'(mdrop[i]), 0);
    end
  endtask
  task automatic do_reset(input int n);
    @(negedge clk_50);
    reset = 1'b1;
    en = 1'b0;
    en3 = 1'b0;
    repeat (n) @(negedge clk_50);
    chk_rst();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) maddr[i] = START[i];
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk_50);
      en = 1'b0;
      en3 = 1'b0;
    end
  endtask
  task automatic word8(input logic [7:0] w);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_50);
      sd = w[i];
      en = 1'b1;
    end
  endtask
  task automatic word12(input logic [11:0] w);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk_50);
      sd3 = w[i];
      en3 = 1'b1;
    end
  endtask
  task automatic partial8(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_50);
      sd = 1'($urandom_range(0, 1));
      en = 1'b1;
    end
    idle(1);
  endtask
  task automatic push(input int i, input logic [11:0] avg);
    eq[i].push_back({maddr[i], avg});
    maddr[i] = DN[i] ? maddr[i] - 11'd1 : maddr[i] + 11'd1;
  endtask
  task automatic pkt8(input logic [7:0] h, input logic [7:0] s [4], input int abort);
    int sum;
    sum = 0;
    word8(h);
    for (int k = 0; k < 4; k++) begin
      if (k == abort) partial8($urandom_range(1, 7));
      word8(s[k]);
      sum += int'(s[k]);
    end
    idle(1);
    if (h == 8'hC3) for (int i = 0; i < 3; i++) push(i, 12'(sum / 4));
    else drop_exp8++;
  endtask
  task automatic pkt12(input logic [11:0] h, input logic [11:0] s [8]);
    int sum;
    sum = 0;
    word12(h);
    for (int k = 0; k < 8; k++) begin
      word12(s[k]);
      sum += int'(s[k]);
    end
    idle(1);
    if (h == 12'hC3C) push(3, 12'(sum / 8));
    else drop_exp12++;
  endtask
  initial begin
    logic [7:0] h;
    logic [7:0] s [4];
    logic [11:0] h12;
    logic [11:0] s12 [8];
    int t;
    do_reset(3);
    pkt8(8'hC3, '{8'd10, 8'd20, 8'd30, 8'd40}, -1);
    idle(8);
    check("addr_step0", int'(ra[0]), 'h7FE);
    check("addr_wrap1", int'(ra[1]), 'h7FF);
    check("addr_wrap2", int'(ra[2]), 'h000);
    pkt8(8'hA5, '{8'd1, 8'd2, 8'd3, 8'd4}, -1);
    pkt8(8'hC3, '{8'd4, 8'd4, 8'd4, 8'd4}, -1);
    pkt8(8'hC3, '{8'd1, 8'd1, 8'd1, 8'd2}, -1);
    pkt8(8'hC3, '{8'hFF, 8'hFF, 8'hFF, 8'hFF}, -1);
    pkt8(8'hC3, '{8'd7, 8'd9, 8'd200, 8'd13}, 2);
    for (int n = 0; n < 40; n++) begin
      h = 8'($urandom);
      if (h == 8'hC3) h = 8'h3C;
      if ($urandom_range(0, 3) != 0) h = 8'hC3;
      for (int k = 0; k < 4; k++) s[k] = 8'($urandom);
      pkt8(h, s, $urandom_range(0, 5) - 1);
    end
    idle(8);
    pkt8(8'hC3, '{8'd50, 8'd60, 8'd70, 8'd80}, -1);
    t = 0;
    while (wr_n[0] && t < 20) begin
      @(negedge clk_50);
      t++;
    end
    check("strobe_seen", int'(wr_n[0]), 0);
    do_reset(1);
    word8(8'hC3);
    word8(8'd90);
    word8(8'd91);
    do_reset(1);
    pkt8(8'hC3, '{8'd3, 8'd5, 8'd7, 8'd9}, -1);
    idle(8);
    pkt12(12'hC3C, '{12'd100, 12'd101, 12'd102, 12'd103, 12'd104, 12'd105, 12'd106, 12'd107});
    for (int n = 0; n < 5; n++) begin
      h12 = n == 1 ? 12'h5A5 : 12'hC3C;
      for (int k = 0; k < 8; k++) s12[k] = 12'($urandom);
      pkt12(h12, s12);
    end
    idle(12);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("q_empty%0d", i), eq[i].size(), 0);
      check($sformatf("drops%0d", i), dseen[i], i < 3 ? drop_exp8 : drop_exp12);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/tas_avg_p.md
# tas_avg_p

Parametrised serial temperature averager: deserialises an LSB-first serial stream into words and groups the words into packets of one header plus 2^NSAMP_LOG2 samples. Packets whose header matches HDR_KEEP are averaged; the result is written to an external RAM through a three-phase write strobe at an auto-stepping address. Other packets are discarded. It is the single-clock, width/depth-configurable successor of the fixed 8-bit, four-sample averager in the data-logging path.

## Interface
- DATA_W, 8: bits per serial word; also header and sample width; must be ≥ 4
- NSAMP_LOG2, 2: log2 of samples per packet (1..4)
- ADDR_W, 11: RAM address width
- HDR_KEEP, 8'hC3: header value (DATA_W bits) that marks a packet to average
- START_ADDR, all ones: first RAM address written
- DIR_DOWN, 1: 1 = address decrements after each write, 0 = increments
- clk_50  in  1  system clock; one clock, all logic on rising edge
- reset  in  1  reset; synchronous, active-high
- serial_data  in  1  serial bit, LSB first, sampled when data_ena = 1
- data_ena  in  1  bit-valid qualifier; stays high for a whole word
- ram_wr_n  out  1  RAM write strobe, active low
- ram_data  out  DATA_W  averaged value to RAM
- ram_addr  out  ADDR_W  RAM write address
- pkt_drop  out  1  one-cycle pulse when a non-matching header is received

## Operation
- Deserialiser: bit counter plus shift register; on each edge with data_ena=1, shift the bit in at the MSB and shift right. After DATA_W accepted bits, the word is complete: word_valid pulses for one cycle and the counter clears.
- data_ena low before DATA_W bits: discard the partial word and clear the counter. The next accepted bit is bit 0 of a new word.
- Packet FSM (HDR, SAMP, SKIP), updated on word_valid only:
  - HDR: if word == HDR_KEEP, clear the accumulator and sample count, go to SAMP. Otherwise pulse pkt_drop and go to SKIP.
  - SAMP: acc += word and count++. On the 2^NSAMP_LOG2-th sample, request a write and go to HDR.
  - SKIP: count++. After 2^NSAMP_LOG2 words, return to HDR.
- Arithmetic: the accumulator is DATA_W+NSAMP_LOG2 bits, unsigned, so it cannot overflow. Average = acc >> NSAMP_LOG2, truncated (no rounding), DATA_W bits.
- Write FSM (IDLE, SETUP, STROBE, HOLD):
  - IDLE: on a write request, latch the average into ram_data and go to SETUP.
  - SETUP → STROBE: ram_wr_n = 0 in STROBE only.
  - STROBE → HOLD.
  - HOLD → IDLE: ram_addr steps by ±1 per DIR_DOWN.
  - ram_data and ram_addr stay stable from SETUP through HOLD.
- Address wraps modulo 2^ADDR_W (0 − 1 → all ones; all ones + 1 → 0). No full flag; older data is overwritten.
- Write overlap: at least DATA_W ≥ 4 cycles separate requests, so a write always finishes before the next request. Reception continues during a write.

## Timing
- Reset values: ram_wr_n=1, ram_data=0, ram_addr=START_ADDR, pkt_drop=0. Both FSMs go to HDR/IDLE; bit counter, sample counter and accumulator are 0.
- Let edge T sample the last bit of the last sample:
  - word_valid is high in cycle T+1.
  - SETUP (data and address driven) at T+2.
  - ram_wr_n=0 for exactly the cycle after edge T+3.
  - HOLD at T+4; the address updates at T+5.
- pkt_drop goes high for one cycle, in the cycle after the header word completes.
- Reset asserted mid-packet or mid-write: everything returns to reset values on the next edge. A strobe already in progress is cut; no partial packet is resumed.
- A reset held for several cycles keeps all outputs at reset values.

## Test plan
- Defaults; send C3, 10, 20, 30, 40 → one strobe; ram_data=25, ram_addr=7FF, ram_wr_n low for exactly 1 cycle; ram_addr becomes 7FE afterwards.
- Send A5, 1, 2, 3, 4, then C3, 4, 4, 4, 4 → pkt_drop pulses once, no write for the first packet; the second packet writes 4 at 7FF.
- Truncation and range: C3, 1, 1, 1, 2 → 1; C3, FF, FF, FF, FF → FF with no overflow.
- data_ena drops after 5 bits of a sample, then the full sample is resent → the partial word is ignored and the average uses only full words.
- Wrap: START_ADDR=0, DIR_DOWN=1, two kept packets → writes at 000 then 7FF. Repeat with DIR_DOWN=0, START_ADDR=7FF → 7FF then 000.
- Reset high for 1 cycle during STROBE and again mid-SAMP → ram_wr_n=1 on the next edge, ram_addr=START_ADDR. A following good packet writes a correct average at START_ADDR.
- Parametrisation: DATA_W=12, NSAMP_LOG2=3, HDR_KEEP=12'hC3C; eight samples 100..107 → 103.
